// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types and constants for the multiplexed 7-segment scanner
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_BLANK
  } scan_state_t;

  localparam int NUM_DIGITS = 4;

  // Any code 10-15 decodes to all segments off; F is used to force a dark digit.
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/seg_scan_ctrl_seg7.sv
// rtl/seg_scan_ctrl_seg7.sv - BCD to {g,f,e,d,c,b,a} active-high segment decoder
module seg_scan_ctrl_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed display scanner with blanking and
// frame-synchronous double-buffered value update
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lz_en,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [3:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int MAX_CNT = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  scan_state_t           state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         div_cnt;
  logic [15:0]           active_data;
  logic [15:0]           shadow_data;
  logic [3:0]            active_dp;
  logic [3:0]            shadow_dp;
  logic                  pend;
  logic                  lz_run;
  logic                  frame_edge;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            dec_in;
  logic [6:0]            dec_seg;

  assign upd_ready = !pend;

  // A digit is dark only while it and every digit to its left are zero with no dp lit.
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      lz_run      = lz_run && (active_data[4*n +: 4] == 4'd0) && !active_dp[n];
      lz_blank[n] = lz_run;
    end
  end

  assign dec_in     = (lz_en && lz_blank[idx]) ? BCD_BLANK : active_data[{idx, 2'b00} +: 4];
  assign frame_edge = enable && (state == ST_BLANK) && (div_cnt == BLANK_LAST) && (idx == LAST_IDX);

  seg_scan_ctrl_seg7 u_seg7 (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      div_cnt     <= '0;
      active_data <= '0;
      active_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pend        <= 1'b0;
      digit_sel   <= '0;
      seg         <= '0;
      dp          <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      // While scanning, a new value waits in the shadow so a frame is never torn.
      if (upd_valid && !pend) begin
        if (state == ST_IDLE) begin
          active_data <= upd_data;
          active_dp   <= upd_dp;
        end else begin
          shadow_data <= upd_data;
          shadow_dp   <= upd_dp;
          pend        <= 1'b1;
        end
      end else if (frame_edge && pend) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        pend        <= 1'b0;
      end

      digit_sel  <= '0;
      seg        <= '0;
      dp         <= 1'b0;
      frame_tick <= frame_edge;

      if (!enable) begin
        state   <= ST_IDLE;
        idx     <= '0;
        div_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SHOW;
            idx     <= '0;
            div_cnt <= '0;
          end
          ST_SHOW: begin
            digit_sel <= 4'b0001 << idx;
            seg       <= dec_seg;
            dp        <= active_dp[idx];
            if (div_cnt == SHOW_LAST) begin
              state   <= ST_BLANK;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          ST_BLANK: begin
            if (div_cnt == BLANK_LAST) begin
              state   <= ST_SHOW;
              div_cnt <= '0;
              idx     <= idx + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYCLES=2)
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * (SCAN_DIV + BLANK_CYCLES);

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;
    bit         glitch;
  } win_t;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        lz_en;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic [3:0]  upd_dp;
  logic        upd_ready;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  win_t obs_q[$];
  exp_t exp_q[$];
  int   tick_q[$];
  bit   in_win = 0;
  win_t cur;
  int   zcnt = 0;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lz_en      (lz_en),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_dp     (upd_dp),
    .upd_ready  (upd_ready),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect each strobe window (digit, segments, length, preceding gap) off the active edge.
  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_q.push_back(cyc);
    if ((|digit_sel) === 1'b1) begin
      if (!in_win) begin
        in_win     = 1;
        cur.sel    = digit_sel;
        cur.seg    = seg;
        cur.dp     = dp;
        cur.len    = 1;
        cur.gap    = zcnt;
        cur.glitch = 0;
      end else begin
        cur.len++;
        if (digit_sel !== cur.sel || seg !== cur.seg || dp !== cur.dp) cur.glitch = 1;
      end
      zcnt = 0;
    end else begin
      if (in_win) obs_q.push_back(cur);
      in_win = 0;
      zcnt++;
    end
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void push_digit(input logic [15:0] v, input logic [3:0] p, input bit lz, input int n);
    exp_t e;
    bit   blank;
    blank = lz && (n > 0);
    for (int k = n; k < 4; k++)
      if (v[4*k +: 4] != 4'd0 || p[k]) blank = 0;
    e.sel = 4'(1 << n);
    e.seg = blank ? 7'h00 : ref_seg(v[4*n +: 4]);
    e.dp  = p[n];
    exp_q.push_back(e);
  endfunction

  function automatic void push_frame(input logic [15:0] v, input logic [3:0] p, input bit lz);
    for (int n = 0; n < 4; n++) push_digit(v, p, lz, n);
  endfunction

  task automatic sb_compare(input int n, input string tag);
    int   k = 0;
    win_t w;
    exp_t e;
    while (obs_q.size() < n && k < 6 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (obs_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s windows: got %0d strobe windows, want %0d", tag, obs_q.size(), n);
    end
    for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      w = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (w.sel !== e.sel || w.seg !== e.seg || w.dp !== e.dp) begin
        n_bad++;
        $display("FAIL %s[%0d] digit: got sel=%b seg=%h dp=%b, want sel=%b seg=%h dp=%b",
                 tag, i, w.sel, w.seg, w.dp, e.sel, e.seg, e.dp);
      end
      n_cmp++;
      if (w.len !== SCAN_DIV || w.glitch) begin
        n_bad++;
        $display("FAIL %s[%0d] show_len: got %0d cycles (glitch=%0d), want %0d steady", tag, i, w.len, w.glitch, SCAN_DIV);
      end
      if (i > 0) begin
        n_cmp++;
        if (w.gap !== BLANK_CYCLES) begin
          n_bad++;
          $display("FAIL %s[%0d] blank_len: got %0d, want %0d", tag, i, w.gap, BLANK_CYCLES);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic wait_sel(input logic [3:0] target, input string tag);
    int k = 0;
    @(negedge clk);
    while (digit_sel !== target && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (digit_sel !== target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s wait: digit_sel=%b, want %b within budget", tag, digit_sel, target);
    end
  endtask

  task automatic restart();
    enable    = 0;
    upd_valid = 0;
    lz_en     = 0;
    reset     = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    tick_q.delete();
  endtask

  task automatic load_idle(input logic [15:0] v, input logic [3:0] p, input string tag);
    upd_data  = v;
    upd_dp    = p;
    upd_valid = 1;
    @(negedge clk);
    n_cmp++;
    if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_idle: got %b, want 1", tag, upd_ready); end
    @(posedge clk); #1;
    upd_valid = 0;
    upd_data  = 16'hDEAD;
    upd_dp    = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_after_idle_load: got %b, want 1", tag, upd_ready); end
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; lz_en = 0; upd_valid = 1; upd_data = 16'h9876; upd_dp = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (digit_sel !== 4'b0)  begin n_bad++; $display("FAIL reset digit_sel: got %b, want 0000", digit_sel); end
    n_cmp++; if (seg !== 7'h00)       begin n_bad++; $display("FAIL reset seg: got %h, want 00", seg); end
    n_cmp++; if (dp !== 1'b0)         begin n_bad++; $display("FAIL reset dp: got %b, want 0", dp); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset frame_tick: got %b, want 0", frame_tick); end
    n_cmp++; if (upd_ready !== 1'b1)  begin n_bad++; $display("FAIL reset upd_ready: got %b, want 1", upd_ready); end
    enable = 0; upd_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    n_cmp++; if (upd_ready !== 1'b1)  begin n_bad++; $display("FAIL post_reset upd_ready: got %b, want 1", upd_ready); end
    n_cmp++; if (digit_sel !== 4'b0)  begin n_bad++; $display("FAIL post_reset digit_sel: got %b, want 0000", digit_sel); end
  endtask

  task automatic test_basic();
    int k = 0;
    restart();
    load_idle(16'h1234, 4'b0000, "basic");
    enable = 1;
    push_frame(16'h1234, 4'b0000, 0);
    push_frame(16'h1234, 4'b0000, 0);
    sb_compare(8, "basic");
    while (tick_q.size() < 2 && k < 3 * FRAME) begin @(negedge clk); k++; end
    n_cmp++;
    if (tick_q.size() < 2) begin
      n_bad++; $display("FAIL basic frame_tick count: got %0d ticks, want 2", tick_q.size());
    end else if (tick_q[1] - tick_q[0] != FRAME) begin
      n_bad++; $display("FAIL basic frame_period: got %0d, want %0d", tick_q[1] - tick_q[0], FRAME);
    end
  endtask

  task automatic test_mid_update();
    int k   = 0;
    int bad = 0;
    restart();
    load_idle(16'h1234, 4'b0000, "mid");
    enable = 1;
    wait_sel(4'b0100, "mid");
    obs_q.delete();
    @(posedge clk); #1;
    upd_valid = 1; upd_data = 16'h0567; upd_dp = 4'b0000;
    @(negedge clk);
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL mid ready_before: got %b, want 1", upd_ready); end
    @(posedge clk); #1;
    upd_valid = 0; upd_data = 16'h9999;
    @(negedge clk);
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL mid ready_after_accept: got %b, want 0", upd_ready); end
    while (frame_tick !== 1'b1 && k < 2 * FRAME) begin
      if (upd_ready !== 1'b0) bad++;
      @(negedge clk);
      k++;
    end
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL mid frame_tick: got %b, want 1 within budget", frame_tick); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid ready_held_low: got %0d cycles high, want 0", bad); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL mid ready_at_boundary: got %b, want 1", upd_ready); end
    push_digit(16'h1234, 4'b0000, 0, 2);
    push_digit(16'h1234, 4'b0000, 0, 3);
    push_frame(16'h0567, 4'b0000, 0);
    sb_compare(6, "mid");
  endtask

  task automatic test_decode_lz();
    restart();
    load_idle(16'hF9A8, 4'b1001, "decode");
    enable = 1;
    push_frame(16'hF9A8, 4'b1001, 0);
    sb_compare(4, "decode");
    restart();
    lz_en = 1;
    load_idle(16'h0007, 4'b0000, "lz_plain");
    enable = 1;
    push_frame(16'h0007, 4'b0000, 1);
    sb_compare(4, "lz_plain");
    restart();
    lz_en = 1;
    load_idle(16'h0007, 4'b0100, "lz_dp");
    enable = 1;
    push_frame(16'h0007, 4'b0100, 1);
    sb_compare(4, "lz_dp");
    restart();
    lz_en = 1;
    load_idle(16'h0000, 4'b0000, "lz_zero");
    enable = 1;
    push_frame(16'h0000, 4'b0000, 1);
    sb_compare(4, "lz_zero");
  endtask

  task automatic test_back_to_back();
    restart();
    load_idle(16'h1234, 4'b0000, "b2b");
    enable = 1;
    wait_sel(4'b0010, "b2b");
    obs_q.delete();
    @(posedge clk); #1;
    upd_valid = 1; upd_data = 16'h0567; upd_dp = 4'b0000;
    @(posedge clk); #1;
    upd_data = 16'h0999; upd_dp = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b ready_while_pending[%0d]: got %b, want 0", i, upd_ready); end
      @(posedge clk); #1;
    end
    upd_valid = 0;
    push_digit(16'h1234, 4'b0000, 0, 1);
    push_digit(16'h1234, 4'b0000, 0, 2);
    push_digit(16'h1234, 4'b0000, 0, 3);
    push_frame(16'h0567, 4'b0000, 0);
    push_frame(16'h0567, 4'b0000, 0);
    sb_compare(11, "b2b");
  endtask

  task automatic test_boundary_accept();
    restart();
    load_idle(16'h1234, 4'b0000, "bnd");
    enable = 1;
    wait_sel(4'b1000, "bnd");
    wait_sel(4'b0000, "bnd");
    upd_valid = 1; upd_data = 16'h0567; upd_dp = 4'b0010;
    @(posedge clk); #1;
    upd_valid = 0;
    obs_q.delete();
    @(negedge clk);
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL bnd tick_on_accept_edge: got %b, want 1", frame_tick); end
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL bnd ready_after_accept: got %b, want 0", upd_ready); end
    push_frame(16'h1234, 4'b0000, 0);
    push_frame(16'h0567, 4'b0010, 0);
    sb_compare(8, "bnd");
  endtask

  task automatic test_enable_drop();
    int bad = 0;
    restart();
    load_idle(16'h1234, 4'b0000, "en");
    enable = 1;
    wait_sel(4'b0100, "en");
    @(posedge clk); #1;
    enable = 0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (digit_sel !== 4'b0 || seg !== 7'h00 || dp !== 1'b0 || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL en outputs_off: got sel=%b seg=%h dp=%b tick=%b, want all 0", digit_sel, seg, dp, frame_tick);
    end
    repeat (6) begin
      @(negedge clk);
      if (digit_sel !== 4'b0 || frame_tick !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL en stays_idle: got %0d active cycles, want 0", bad); end
    @(posedge clk); #1;
    obs_q.delete();
    tick_q.delete();
    enable = 1;
    push_frame(16'h1234, 4'b0000, 0);
    sb_compare(4, "en_restart");
  endtask

  task automatic test_reset_pending();
    restart();
    enable = 0;
    load_idle(16'h1234, 4'b0000, "rstp");
    enable = 1;
    wait_sel(4'b0010, "rstp");
    @(posedge clk); #1;
    upd_valid = 1; upd_data = 16'h0567; upd_dp = 4'b0001;
    @(posedge clk); #1;
    upd_valid = 0;
    @(negedge clk);
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL rstp pend_set: got %b, want 0", upd_ready); end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rstp ready: got %b, want 1", upd_ready); end
    n_cmp++;
    if (digit_sel !== 4'b0 || seg !== 7'h00 || dp !== 1'b0 || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL rstp outputs: got sel=%b seg=%h dp=%b tick=%b, want all 0", digit_sel, seg, dp, frame_tick);
    end
    @(posedge clk); #1;
    obs_q.delete();
    push_frame(16'h0000, 4'b0000, 0);
    push_frame(16'h0000, 4'b0000, 0);
    sb_compare(8, "rstp");
  endtask

  initial begin
    reset = 1; enable = 0; lz_en = 0; upd_valid = 0; upd_data = '0; upd_dp = '0;
    test_reset();
    test_basic();
    test_mid_update();
    test_decode_lz();
    test_back_to_back();
    test_boundary_accept();
    test_enable_drop();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
